seg_pulse_counter: RTL

SEG_PULSE_COUNTER -- requirements
Module: seg_pulse_counter

---
 rtl/seg_pkg.sv | 29 ++
 rtl/sig_debounce.sv | 43 ++++
 rtl/seg_pulse_counter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the pulse counter display: FSM encoding, BCD digit
// width and the 7-segment decode table.
package seg_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Segment patterns for 0-9, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Non-decimal codes blank the digit rather than showing garbage.
    function automatic logic [6:0] seg_decode(input bcd_t d);
        if (d > 4'd9) begin
            return 7'h00;
        end
        return SEG_LUT[d];
    endfunction

endpackage

// File: rtl/sig_debounce.sv
// Debounces an already-synchronised level and flags its 0->1 transitions.
module sig_debounce #(
    parameter int DEB_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    // Accept a new level once it has differed for DEB_CYC consecutive cycles.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (i_level != r_level) begin
                if (r_cnt == CNT_W'(DEB_CYC - 1)) begin
                    r_level <= i_level;
                    r_cnt   <= '0;
                    r_rise  <= i_level;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/seg_pulse_counter.sv
// Pulse counter with burst detection, shown on a multiplexed 7-segment display.
// Digits 1:0 show the last closed burst, the upper digits the running total.
module seg_pulse_counter
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 100000,
    parameter int DEB_CYC  = 1000,
    parameter int GAP_CYC  = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    input  logic                signal,
    output logic [N_DIGITS-1:0] led_en,
    output logic                led_ca,
    output logic                led_cb,
    output logic                led_cc,
    output logic                led_cd,
    output logic                led_ce,
    output logic                led_cf,
    output logic                led_cg,
    output logic                led_dp
);

    localparam int TOT_DIGITS = N_DIGITS - 2;
    localparam int IDX_W      = $clog2(N_DIGITS);
    localparam int DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int GAP_W      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [N_DIGITS-1:0] EN_ONE = N_DIGITS'(1);

    logic r_btn_meta, r_btn_sync, r_btn_prev;
    logic r_sig_meta, r_sig_sync;
    logic w_btn_press, w_sig_edge;

    state_t r_state, w_state_next;
    logic   w_run, w_hold, w_clear;

    logic [TOT_DIGITS-1:0][BCD_W-1:0] r_total, w_total_inc;
    logic [1:0][BCD_W-1:0]            r_burst, r_last_burst, w_burst_inc;
    logic                             r_overflow, w_total_wrap;
    logic [GAP_W-1:0]                 r_gap;
    logic                             w_count, w_expire;

    logic [DIV_W-1:0]    r_scan_cnt;
    logic [IDX_W-1:0]    r_scan_idx;
    bcd_t                w_digit_val;
    logic                w_dp_on;
    logic                r_rst_d;
    logic [N_DIGITS-1:0] r_led_en;
    logic [6:0]          r_seg_n;
    logic                r_dp_n;

    // Two-flop synchronisers on both asynchronous inputs, plus button history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_prev <= 1'b0;
            r_sig_meta <= 1'b0;
            r_sig_sync <= 1'b0;
        end else begin
            r_btn_meta <= button;
            r_btn_sync <= r_btn_meta;
            r_btn_prev <= r_btn_sync;
            r_sig_meta <= signal;
            r_sig_sync <= r_sig_meta;
        end
    end

    assign w_btn_press = r_btn_sync & ~r_btn_prev;

    sig_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_sig_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_level (r_sig_sync),
        .o_rise  (w_sig_edge)
    );

    // Mode FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Mode FSM next state: each press steps IDLE -> RUN -> HOLD -> IDLE.
    always_comb begin
        // NOTE: the default first assignment keeps this block free of latches.
        w_state_next = r_state;
        if (w_btn_press) begin
            case (r_state)
                ST_IDLE: w_state_next = ST_RUN;
                ST_RUN:  w_state_next = ST_HOLD;
                ST_HOLD: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Mode FSM outputs; a press in RUN wins over a same-cycle signal edge.
    always_comb begin
        w_run   = (r_state == ST_RUN) && !w_btn_press;
        w_hold  = (r_state == ST_HOLD);
        w_clear = w_btn_press && (r_state != ST_RUN);
    end

    // BCD increment of the total; a carry out of the top digit means wrap.
    always_comb begin
        logic v_carry;
        v_carry     = 1'b1;
        w_total_inc = r_total;
        for (int k = 0; k < TOT_DIGITS; k++) begin
            if (v_carry) begin
                if (r_total[k] == 4'd9) begin
                    w_total_inc[k] = '0;
                end else begin
                    w_total_inc[k] = r_total[k] + 4'd1;
                    v_carry        = 1'b0;
                end
            end
        end
        w_total_wrap = v_carry;
    end

    // Saturating two-digit BCD increment of the burst count.
    always_comb begin
        w_burst_inc = r_burst;
        if (r_burst == 8'h99) begin
            w_burst_inc = r_burst;
        end else if (r_burst[0] == 4'd9) begin
            w_burst_inc[0] = '0;
            w_burst_inc[1] = r_burst[1] + 4'd1;
        end else begin
            w_burst_inc[0] = r_burst[0] + 4'd1;
        end
    end

    assign w_count  = w_run && w_sig_edge;
    assign w_expire = w_run && (|r_burst) && (r_gap == GAP_W'(GAP_CYC - 1));

    // Counters and gap timer; they only move in RUN, so HOLD freezes them.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_total      <= '0;
            r_burst      <= '0;
            r_last_burst <= '0;
            r_overflow   <= 1'b0;
            r_gap        <= '0;
        end else if (w_count) begin
            r_total <= w_total_inc;
            r_gap   <= '0;
            if (w_total_wrap) begin
                r_overflow <= 1'b1;
            end
            if (w_expire) begin
                r_last_burst <= r_burst;
                r_burst      <= 8'h01;
            end else begin
                r_burst <= w_burst_inc;
            end
        end else if (w_expire) begin
            r_last_burst <= r_burst;
            r_burst      <= '0;
            r_gap        <= '0;
        end else if (w_run && (|r_burst)) begin
            r_gap <= r_gap + GAP_W'(1);
        end
    end

    // Round-robin digit scan, one digit every SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == DIV_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            if (r_scan_idx == IDX_W'(N_DIGITS - 1)) begin
                r_scan_idx <= '0;
            end else begin
                r_scan_idx <= r_scan_idx + IDX_W'(1);
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + DIV_W'(1);
        end
    end

    // Select the value and decimal point for the digit currently scanned.
    always_comb begin
        w_digit_val = '0;
        if (r_scan_idx == IDX_W'(0)) begin
            w_digit_val = r_last_burst[0];
        end else if (r_scan_idx == IDX_W'(1)) begin
            w_digit_val = r_last_burst[1];
        end
        for (int k = 0; k < TOT_DIGITS; k++) begin
            if (r_scan_idx == IDX_W'(k + 2)) begin
                w_digit_val = r_total[k];
            end
        end
        w_dp_on = (r_scan_idx == IDX_W'(2))
                || ((r_scan_idx == IDX_W'(0)) && w_hold)
                || ((r_scan_idx == IDX_W'(N_DIGITS - 1)) && r_overflow);
    end

    // Registered display drive, held dark during reset and the cycle after.
    always_ff @(posedge clk) begin
        r_rst_d <= rst;
        if (rst || r_rst_d) begin
            r_led_en <= '1;
            r_seg_n  <= '1;
            r_dp_n   <= 1'b1;
        end else begin
            r_led_en <= ~(EN_ONE << r_scan_idx);
            r_seg_n  <= ~seg_decode(w_digit_val);
            r_dp_n   <= ~w_dp_on;
        end
    end

    assign led_en = r_led_en;
    assign {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = r_seg_n;
    assign led_dp = r_dp_n;

endmodule
